// File: rtl/uk101_pkg.sv
// rtl/uk101_pkg.sv - shared types and character constants for the UK101 ascii loader
package uk101_pkg;

    // Presentation FSM states of the ascii loader
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } ldr_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush, shared by the ascii loader and UART receive buffer
// A flush empties the FIFO and a push in the same cycle lands in the freshly
// emptied storage. A pop is ignored while empty or flushing; a push into a full
// FIFO is dropped unless a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_LEVEL);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Next-state of storage, pointers and occupancy for push/pop/flush
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop & ~empty & ~flush;
        do_push  = push & (flush | ~full | do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        if (do_push) begin
            mem_d[wr_ptr_d] = din;
            wr_ptr_d        = wr_ptr_d + AW'(1);
            count_d         = count_d + CW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            count_d  = count_d - CW'(1);
        end
    end

    // FIFO state registers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ascii_loader.sv
// rtl/ascii_loader.sv - paces a downloaded text file into the UK101 ACIA receive path
// Bytes from hps_io are line-ending filtered (LF and CRLF become a single CR),
// buffered, and handed to the ACIA one at a time with a short gap after each
// character and a long gap after each CR so BASIC can tokenise the line.
module ascii_loader
    import uk101_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CHAR_GAP   = 48000,
    parameter int LINE_GAP   = 4800000
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       sel_file,
    input  logic       ioctl_download,
    input  logic       ioctl_wr,
    input  logic [7:0] ioctl_data,
    output logic       ioctl_wait,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       loading,
    output logic       overflow
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int GW = $clog2(LINE_GAP + 1);
    localparam logic [CW-1:0] WAIT_LEVEL = CW'(FIFO_DEPTH - 2);
    localparam logic [GW-1:0] CHAR_LOAD  = GW'(CHAR_GAP);
    localparam logic [GW-1:0] LINE_LOAD  = GW'(LINE_GAP);

    ldr_state_t    state_q, state_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          last_cr_q, last_cr_d;
    logic          overflow_q, overflow_d;
    logic          dl_q;

    logic          dl_rise;
    logic          last_cr_eff;
    logic          fifo_flush;
    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_din;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .flush   (fifo_flush),
        .push    (fifo_push),
        .din     (fifo_din),
        .pop     (fifo_pop),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // The two-entry margin lets a write already in flight still land
    assign ioctl_wait = sel_file & (fifo_count >= WAIT_LEVEL);
    assign loading    = sel_file & (ioctl_download | ~fifo_empty | (state_q != IDLE));
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign overflow   = overflow_q;

    // Write filter, download restart and presentation FSM next-state
    always_comb begin
        dl_rise     = ioctl_download & ~dl_q;
        last_cr_eff = last_cr_q & ~dl_rise;
        state_d     = state_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        gap_cnt_d   = gap_cnt_q;
        last_cr_d   = last_cr_eff;
        overflow_d  = overflow_q & ~dl_rise;
        fifo_flush  = dl_rise;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        fifo_din    = ioctl_data;

        // Line-ending filter: LF right after CR vanishes, any other LF becomes CR
        if (ioctl_wr && sel_file) begin
            if (ioctl_data == ASCII_LF) begin
                if (last_cr_eff) begin
                    last_cr_d = 1'b0;
                end else begin
                    fifo_din  = ASCII_CR;
                    fifo_push = 1'b1;
                    last_cr_d = 1'b1;
                end
            end else if (ioctl_data == ASCII_CR) begin
                fifo_push = 1'b1;
                last_cr_d = 1'b1;
            end else begin
                fifo_push = 1'b1;
                last_cr_d = 1'b0;
            end
        end

        if (!sel_file) begin
            state_d    = IDLE;
            rx_valid_d = 1'b0;
            fifo_flush = 1'b1;
        end else if (dl_rise) begin
            state_d    = IDLE;
            rx_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rx_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        rx_data_d  = fifo_dout;
                        rx_valid_d = 1'b1;
                        state_d    = PRESENT;
                    end
                end
                PRESENT: begin
                    if (rx_ack && rx_valid_q) begin
                        gap_cnt_d  = (rx_data_q == ASCII_CR) ? LINE_LOAD : CHAR_LOAD;
                        rx_valid_d = 1'b0;
                        state_d    = GAP;
                    end
                end
                GAP: begin
                    rx_valid_d = 1'b0;
                    if (gap_cnt_q == '0) begin
                        if (!fifo_empty) begin
                            fifo_pop   = 1'b1;
                            rx_data_d  = fifo_dout;
                            rx_valid_d = 1'b1;
                            state_d    = PRESENT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q - GW'(1);
                    end
                end
                default: begin
                    state_d    = IDLE;
                    rx_valid_d = 1'b0;
                end
            endcase
        end

        // A byte is lost only if the FIFO stays full through this cycle
        if (fifo_push && fifo_full && !fifo_pop && !fifo_flush) begin
            overflow_d = 1'b1;
        end
    end

    // Loader state registers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= IDLE;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            gap_cnt_q  <= '0;
            last_cr_q  <= 1'b0;
            overflow_q <= 1'b0;
            dl_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            gap_cnt_q  <= gap_cnt_d;
            last_cr_q  <= last_cr_d;
            overflow_q <= overflow_d;
            dl_q       <= ioctl_download;
        end
    end

endmodule

// File: tb/tb_ascii_loader.sv
// tb/tb_ascii_loader.sv - self-checking bench for ascii_loader
module tb_ascii_loader;

    localparam int DEPTH = 16;
    localparam int CG    = 4;
    localparam int LG    = 20;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       sel_file = 1'b1;
    logic       ioctl_download = 1'b0;
    logic       ioctl_wr = 1'b0;
    logic [7:0] ioctl_data = 8'h00;
    logic       ioctl_wait;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack = 1'b0;
    logic       loading;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] got_q[$];
    int         rise_q[$];
    logic [7:0] exp_q[$];
    bit         model_lcr = 1'b0;
    bit         auto_ack = 1'b0;
    int         since = 0;
    logic       prev_valid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ascii_loader #(
        .FIFO_DEPTH (DEPTH),
        .CHAR_GAP   (CG),
        .LINE_GAP   (LG)
    ) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .sel_file       (sel_file),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_data     (ioctl_data),
        .ioctl_wait     (ioctl_wait),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ack         (rx_ack),
        .loading        (loading),
        .overflow       (overflow)
    );

    // ACIA stand-in: records each presented character, acks two cycles later
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rx_ack = 1'b0;
            if (rx_valid && !prev_valid) begin
                got_q.push_back(rx_data);
                rise_q.push_back(cyc);
                since = 0;
            end else if (rx_valid) begin
                since++;
            end
            if (auto_ack && rx_valid && since >= 2) rx_ack = 1'b1;
            prev_valid = rx_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Reference: a LF right after a CR is half of a CRLF and vanishes; any
    // other LF ends a line and is delivered as CR; everything else passes.
    task automatic model_push(input logic [7:0] b);
        if (b == LF && model_lcr) begin
            model_lcr = 1'b0;
        end else begin
            exp_q.push_back((b == LF) ? CR : b);
            model_lcr = (b == LF) || (b == CR);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic start_file();
        ioctl_download = 1'b0;
        step();
        ioctl_download = 1'b1;
        got_q.delete();
        rise_q.delete();
        exp_q.delete();
        model_lcr = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        ioctl_wr   = 1'b1;
        ioctl_data = b;
        model_push(b);
        step();
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (got_q.size() >= n) ok = 1'b1;
            else step();
        end
        if (got_q.size() >= n) ok = 1'b1;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        idle(3);
        n_reset = 1'b1;
        step();
        checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b want 0", ioctl_wait); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++; if (loading !== 1'b0) begin errors++; $display("FAIL reset_loading: got %b want 0", loading); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_crlf();
        bit ok;
        start_file();
        auto_ack = 1'b1;
        write_byte(8'h41);
        write_byte(8'h42);
        write_byte(CR);
        write_byte(LF);
        wait_bytes(3, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL crlf_timeout: got %0d bytes want 3", got_q.size()); end
        write_byte(8'h43);
        wait_bytes(4, 200, ok);
        idle(LG + 10);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL crlf_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL crlf_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        for (int i = 0; i + 1 < rise_q.size() && i < 3; i++) begin
            checks++;
            if (rise_q[i+1] - rise_q[i] != ((exp_q[i] == CR) ? LG : CG) + 4) begin
                errors++;
                $display("FAIL crlf_gap%0d: got %0d want %0d", i, rise_q[i+1] - rise_q[i], ((exp_q[i] == CR) ? LG : CG) + 4);
            end
        end
        ioctl_download = 1'b0;
        step();
    endtask

    task automatic test_lone_lf();
        bit ok;
        int r;
        start_file();
        auto_ack = 1'b1;
        write_byte(8'h58);
        write_byte(LF);
        write_byte(8'h59);
        wait_bytes(3, 200, ok);
        idle(10);
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL lf_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL lf_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        ioctl_download = 1'b0;
        idle(LG + 10);
        start_file();
        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 3);
            if (r == 0) write_byte(LF);
            else if (r == 1) write_byte(CR);
            else write_byte(8'($urandom_range(32, 126)));
        end
        wait_bytes(exp_q.size(), 12 * (LG + 8), ok);
        idle(LG + 10);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        ioctl_download = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        bit ok;
        logic [7:0] burst [20];
        start_file();
        auto_ack = 1'b0;
        write_byte(8'h21);
        wait_bytes(1, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_primer: got %0d bytes want 1", got_q.size()); end
        for (int k = 0; k < 20; k++) begin
            burst[k]   = 8'($urandom_range(32, 126));
            ioctl_wr   = 1'b1;
            ioctl_data = burst[k];
            step();
            checks++;
            if (ioctl_wait !== (k + 1 >= DEPTH - 2)) begin
                errors++;
                $display("FAIL ovf_wait_after%0d: got %b want %b", k + 1, ioctl_wait, (k + 1 >= DEPTH - 2));
            end
        end
        ioctl_wr = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        // The held primer plus one FIFO-full of the burst survive
        for (int i = 0; i < DEPTH; i++) model_push(burst[i]);
        auto_ack = 1'b1;
        wait_bytes(exp_q.size(), 20 * (CG + 6), ok);
        idle(20);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        ioctl_download = 1'b0;
        step();
    endtask

    task automatic test_wait_honour();
        bit ok;
        bit saw_wait;
        int idx;
        logic [7:0] data [20];
        for (int i = 0; i < 20; i++) data[i] = 8'($urandom_range(32, 126));
        start_file();
        auto_ack = 1'b1;
        idx = 0;
        saw_wait = 1'b0;
        for (int t = 0; t < 2000 && idx < 20; t++) begin
            if (!ioctl_wait) begin
                ioctl_wr   = 1'b1;
                ioctl_data = data[idx];
                model_push(data[idx]);
                idx++;
            end else begin
                ioctl_wr = 1'b0;
                saw_wait = 1'b1;
            end
            step();
        end
        ioctl_wr = 1'b0;
        checks++; if (idx != 20) begin errors++; $display("FAIL wait_sent: got %0d want 20", idx); end
        checks++; if (!saw_wait) begin errors++; $display("FAIL wait_seen: got 0 want 1"); end
        wait_bytes(20, 20 * (CG + 6), ok);
        idle(20);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wait_overflow: got %b want 0", overflow); end
        checks++; if (got_q.size() != 20) begin errors++; $display("FAIL wait_count: got %0d want 20", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL wait_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        ioctl_download = 1'b0;
        step();
    endtask

    task automatic test_reset_in_gap();
        bit ok;
        bit in_gap;
        int base;
        start_file();
        auto_ack = 1'b1;
        for (int i = 0; i < 6; i++) write_byte(8'(8'h30 + i));
        in_gap = 1'b0;
        for (int t = 0; t < 50 && !in_gap; t++) begin
            if (got_q.size() >= 1 && !rx_valid) in_gap = 1'b1;
            else step();
        end
        checks++; if (!in_gap) begin errors++; $display("FAIL rst_reach_gap: got 0 want 1"); end
        n_reset        = 1'b0;
        ioctl_download = 1'b0;
        #1;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
        checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL rst_wait: got %b want 0", ioctl_wait); end
        checks++; if (loading !== 1'b0) begin errors++; $display("FAIL rst_loading: got %b want 0", loading); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        step();
        n_reset = 1'b1;
        base = got_q.size();
        idle(40);
        checks++; if (got_q.size() != base) begin errors++; $display("FAIL rst_no_replay: got %0d bytes want %0d", got_q.size(), base); end
        checks++; if (loading !== 1'b0) begin errors++; $display("FAIL rst_idle_loading: got %b want 0", loading); end
        start_file();
        write_byte(8'h36);
        wait_bytes(1, 20, ok);
        idle(5);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rst_new_count: got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            checks++; if (got_q[0] !== 8'h36) begin errors++; $display("FAIL rst_new_byte: got %h want 36", got_q[0]); end
        end
        ioctl_download = 1'b0;
        idle(CG + 4);
    endtask

    task automatic test_sel_file_drop();
        bit ok;
        int base;
        start_file();
        auto_ack = 1'b0;
        for (int k = 0; k < 20; k++) begin
            ioctl_wr   = 1'b1;
            ioctl_data = 8'(8'h61 + k);
            step();
        end
        ioctl_wr = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drop_pre_overflow: got %b want 1", overflow); end
        sel_file = 1'b0;
        step();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL drop_rx_valid: got %b want 0", rx_valid); end
        checks++; if (loading !== 1'b0) begin errors++; $display("FAIL drop_loading: got %b want 0", loading); end
        checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL drop_wait: got %b want 0", ioctl_wait); end
        base = got_q.size();
        auto_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ioctl_wr   = 1'b1;
            ioctl_data = 8'h55;
            step();
            ioctl_wr = 1'b0;
            step();
        end
        idle(30);
        checks++; if (got_q.size() != base) begin errors++; $display("FAIL drop_ignored: got %0d bytes want %0d", got_q.size(), base); end
        sel_file = 1'b1;
        start_file();
        step();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL restart_overflow: got %b want 0", overflow); end
        write_byte(8'h5A);
        wait_bytes(1, 20, ok);
        idle(CG + 8);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL restart_count: got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            checks++; if (got_q[0] !== 8'h5A) begin errors++; $display("FAIL restart_byte: got %h want 5a", got_q[0]); end
        end
        ioctl_download = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_crlf();
        test_lone_lf();
        test_overflow();
        test_wait_honour();
        test_reset_in_gap();
        test_sel_file_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ascii_loader.md
# ascii_loader

Byte-pacing bridge between the HPS file-download port and the UK101 serial receive path. It accepts the bytes of a "Load Ascii" text file from hps_io, buffers them in a small FIFO, and throttles the OSD transfer with ioctl_wait. It converts line endings to the single CR that the UK101 monitor and BASIC expect, and presents one character at a time to the ACIA receive side, with inter-character and end-of-line gaps long enough for BASIC to tokenise each line.

## Interface
- FIFO_DEPTH, 16, FIFO entries; power of two, minimum 4.
- CHAR_GAP, 48000, idle clk cycles after each acknowledged non-CR byte (1 ms at 48 MHz).
- LINE_GAP, 4800000, idle clk cycles after each acknowledged CR (100 ms at 48 MHz).
- clk  in  1  system clock (clk_sys, 48 MHz).
- n_reset  in  1  asynchronous, active-low reset.
- sel_file  in  1  1 = file load mode (loadFrom = File); 0 = UART mode, block inert.
- ioctl_download  in  1  download in progress, from hps_io.
- ioctl_wr  in  1  one-cycle write strobe for ioctl_data.
- ioctl_data  in  8  file byte.
- ioctl_wait  out  1  backpressure to hps_io.
- rx_data  out  8  character presented to the ACIA receive mux.
- rx_valid  out  1  rx_data is valid and unread.
- rx_ack  in  1  one-cycle strobe: the ACIA has read rx_data.
- loading  out  1  transfer active; drives the LED and holds the UART path off.
- overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.

## Operation
- Reset values: ioctl_wait=0, rx_data=0x00, rx_valid=0, loading=0, overflow=0. FIFO empty, FSM in IDLE, last_cr=0.
- A rising edge of ioctl_download (sampled against a registered copy) does the following in one cycle: flushes the FIFO, forces the FSM to IDLE, clears overflow and clears last_cr. A write in that same cycle is still accepted after the flush.
- Write filter, applied only when ioctl_wr=1 and sel_file=1:
  - byte 0x0A with last_cr=1: dropped, and last_cr is cleared. This collapses CRLF to CR.
  - byte 0x0A with last_cr=0: written as 0x0D, and last_cr is set.
  - byte 0x0D: written, and last_cr is set.
  - any other byte: written unchanged, and last_cr is cleared.
- Write into a full FIFO: the byte is dropped and overflow is set. The count does not change.
- ioctl_wait = sel_file & (count >= FIFO_DEPTH-2). The two-entry margin absorbs a write already in flight.
- FSM states:
  - IDLE: rx_valid=0. Moves to PRESENT when the FIFO is not empty.
  - PRESENT: pops the FIFO head into rx_data on entry and holds rx_valid=1. On rx_ack, loads gap_cnt with LINE_GAP if rx_data==0x0D, otherwise with CHAR_GAP, and moves to GAP.
  - GAP: rx_valid=0 and gap_cnt decrements. When gap_cnt reaches 0, moves to PRESENT if the FIFO is not empty, otherwise to IDLE.
- sel_file=0: writes are ignored, ioctl_wait=0 and rx_valid is forced to 0. The FSM returns to IDLE and the FIFO is flushed.
- loading = sel_file & (ioctl_download | FIFO not empty | state != IDLE).

## Timing
- A write at cycle N into an empty FIFO while in IDLE: count=1 at N+1, rx_valid=1 with the byte at N+2.
- rx_ack is honoured only while rx_valid=1; rx_ack at any other time is ignored. After rx_ack at cycle M, rx_valid=0 from M+1.
- The next rx_valid rises at M+1+gap+1, where gap is CHAR_GAP or LINE_GAP.
- A push and a pop in the same cycle are both performed; the count is unchanged. A pop from the full FIFO, plus a push, in the same cycle is not an overflow.
- ioctl_wait is combinational from the registered count and updates one cycle after each push or pop.
- gap_cnt width is $clog2(LINE_GAP+1); LINE_GAP must be >= CHAR_GAP.
- Asynchronous reset mid-transfer returns every output to its reset value immediately. A partially presented byte is lost.

## Structure
- uk101_pkg holds:
  - the ldr_state_t enum {IDLE, PRESENT, GAP};
  - the constants ASCII_CR=8'h0D and ASCII_LF=8'h0A.
- Sub-module sync_fifo: parameterised on width and depth; provides push, pop, flush, dout, count, empty and full. It is reusable by the UART receive buffer.
- The top-level instantiates ascii_loader inside uk101. It sits between the ioctl_* signals and the ACIA receive mux, which is selected by loading.

## Test plan
- Bench parameters: CHAR_GAP=4, LINE_GAP=20. Write "AB\r\n" (0x41, 0x42, 0x0D, 0x0A) with an ack 2 cycles after each rx_valid. Required: the bench sees 0x41, 0x42, 0x0D only; the gaps between rx_valid rising edges are 8, 8 and 24 cycles (gap + 4 cycles of handshake).
- Write lone 0x0A bytes, "X\nY": required output 0x58, 0x0D, 0x59.
- Burst 20 bytes, one per cycle, with FIFO_DEPTH=16 and the bench ignoring ioctl_wait: ioctl_wait rises when count reaches 14, overflow=1, and the bytes after the 16th are absent. Repeat while honouring ioctl_wait: all 20 bytes are delivered in order and overflow=0.
- Assert n_reset=0 while the FSM is in GAP with 5 bytes queued: all outputs are 0 immediately. After release, no byte is presented until a new write arrives.
- Drop sel_file to 0 mid-file: rx_valid=0 and loading=0 the next cycle, and later ioctl_wr pulses are ignored. A new ioctl_download rising edge with sel_file=1 clears overflow and restarts cleanly.
